// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop computes
// {cout,sum} = a + b + cin over WIDTH clocks, LSB first, with a valid/ready handshake.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, sum_q;
  logic               carry_q, cout_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, last_bit;
  logic [1:0]         fa_out;

  // Two half adders plus an OR; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic h;
    h = x ^ y;
    return {(x & y) | (h & ci), h ^ ci};
  endfunction

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign fa_out   = full_add(a_sh_q[0], b_sh_q[0], carry_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
  end

  // Operands are captured on accept, so later input changes cannot reach the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sh_q  <= a;
      b_sh_q  <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
      sum_q   <= {fa_out[0], sum_q[WIDTH-1:1]};
      carry_q <= fa_out[1];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_bit) cout_q <= fa_out[1];
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8): latency, carry corners, DONE hold,
// ignored input, mid-run reset, back-to-back throughput and randomized operands.
module tb_bit_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  logic [W:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_wait in_ready=%b required 1", in_ready);
    end
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    exp_q.push_back(model(xa, xb, xc));
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic collect(output int lat, output bit tmo);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    tmo = (out_valid !== 1'b1);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = '1; b = '1; cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_flags in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if ({cout, sum} !== '0) begin
      errors++; $display("FAIL reset_result got=%h required 000", {cout, sum});
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; bit tmo; logic [W:0] want;
    send(8'h0F, 8'h01, 1'b0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    collect(lat, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout out_valid=%b required 1", out_valid); end
    checks++;
    if (lat != W) begin errors++; $display("FAIL basic_latency got=%0d required %0d", lat, W); end
    want = exp_q.pop_front();
    checks++;
    if ({cout, sum} !== want) begin errors++; $display("FAIL basic_sum got=%h required %h", {cout, sum}, want); end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry;
    logic [2*W:0] tbl [3];
    int lat; bit tmo; logic [W:0] want;
    tbl[0] = {8'hFF, 8'h01, 1'b0};
    tbl[1] = {8'hFF, 8'hFF, 1'b1};
    tbl[2] = {8'h00, 8'h00, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(tbl[i][2*W:W+1], tbl[i][W:1], tbl[i][0]);
      collect(lat, tmo);
      want = exp_q.pop_front();
      checks++;
      if (tmo !== 1'b0 || {cout, sum} !== want) begin
        errors++; $display("FAIL carry_%0d got=%h required %h timeout=%b", i, {cout, sum}, want, tmo);
      end
      release_out();
    end
  endtask

  task automatic test_hold;
    int lat; bit tmo; logic [W:0] want;
    send(8'h3C, 8'h5A, 1'b1);
    collect(lat, tmo);
    want = exp_q.pop_front();
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tmo !== 1'b0 || {out_valid, in_ready, cout, sum} !== {2'b10, want}) begin
        errors++; $display("FAIL hold_%0d ov/ir/result=%b%b/%h required 10/%h", i, out_valid, in_ready, {cout, sum}, want);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore;
    int lat; bit tmo; logic [W:0] want;
    send(8'h12, 8'h34, 1'b0);
    in_valid = 1'b1; a = 8'hAA; b = 8'hFF; cin = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    collect(lat, tmo);
    want = exp_q.pop_front();
    checks++;
    if (tmo !== 1'b0 || {cout, sum} !== want) begin
      errors++; $display("FAIL ignore_sum got=%h required %h timeout=%b", {cout, sum}, want, tmo);
    end
    release_out();
  endtask

  task automatic test_mid_reset;
    int lat; bit tmo; bit seen; logic [W:0] want;
    send(8'h55, 8'h11, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid, cout, sum} !== {3'b100, {(W+1){1'b0}}}) begin
      errors++; $display("FAIL midrst_state ir/busy/ov=%b%b%b result=%h required 100/000", in_ready, busy, out_valid, {cout, sum});
    end
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_pulse out_valid seen=%b required 0", seen); end
    send(8'h80, 8'h80, 1'b0);
    collect(lat, tmo);
    want = exp_q.pop_front();
    checks++;
    if (tmo !== 1'b0 || {cout, sum} !== want) begin
      errors++; $display("FAIL midrst_next got=%h required %h timeout=%b", {cout, sum}, want, tmo);
    end
    release_out();
  endtask

  task automatic test_back_to_back;
    int first, second; logic [W:0] want;
    first = -1; second = -1;
    out_ready = 1'b1; in_valid = 1'b1; a = 8'hC3; b = 8'h4E; cin = 1'b1;
    exp_q.push_back(model(a, b, cin));
    @(negedge clk);
    a = 8'h7D; b = 8'h99; cin = 1'b0;
    exp_q.push_back(model(a, b, cin));
    for (int k = 0; k <= 30; k++) begin
      if (out_valid === 1'b1) begin
        if (first < 0) first = k; else if (second < 0) second = k;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({cout, sum} !== want) begin
          errors++; $display("FAIL b2b_sum k=%0d got=%h required %h", k, {cout, sum}, want);
        end
      end
      if (first >= 0 && busy === 1'b1) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (first != W) begin errors++; $display("FAIL b2b_first got=%0d required %0d", first, W); end
    checks++;
    if (second - first != W + 2) begin
      errors++; $display("FAIL b2b_period got=%0d required %0d", second - first, W + 2);
    end
  endtask

  task automatic test_random;
    bit checked, done; logic [W:0] want;
    for (int n = 0; n < 200; n++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      checked = 1'b0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        if (out_valid === 1'b1 && !checked) begin
          want = exp_q.pop_front();
          checked = 1'b1;
          checks++;
          if ({cout, sum} !== want) begin
            errors++; $display("FAIL random_%0d got=%h required %h", n, {cout, sum}, want);
          end
        end
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (checked && out_valid === 1'b0) done = 1'b1;
      end
      out_ready = 1'b0;
      if (!done) begin
        checks++; errors++;
        $display("FAIL random_timeout op=%0d out_valid=%b required handshake", n, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: in_valid  input  1  upstream asserts when a, b, cin are valid.
REQ-005 Port: in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry into bit 0.
REQ-009 Port: out_valid  output  1  sum and cout are valid.
REQ-010 Port: out_ready  input  1  downstream accepts result this cycle.
REQ-011 Port: sum  output  WIDTH  result bits, registered.
REQ-012 Port: cout  output  1  carry out of bit WIDTH-1, registered.
REQ-013 Port: busy  output  1  high in RUN state.

Function
REQ-014 The block SHALL compute {cout,sum} = a + b + cin, one bit per clock, LSB first, using one half-adder-pair full-adder cell plus a carry flip-flop.
REQ-015 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-016 in_ready SHALL equal 1 only in IDLE; busy SHALL equal 1 only in RUN; out_valid SHALL equal 1 only in DONE.
REQ-017 Accept: IDLE with in_valid=1 at a rising edge SHALL load a, b into shift registers, load cin into the carry flip-flop, clear the bit counter, and enter RUN.
REQ-018 Each RUN edge: sum bit = a_sh[0] ^ b_sh[0] ^ carry; carry <= majority(a_sh[0], b_sh[0], carry); a_sh, b_sh shift right by one; sum bit shifts into sum register from the MSB side; counter increments.
REQ-019 After the WIDTH-th RUN edge the FSM SHALL enter DONE with sum holding the full result and cout equal to the final carry; out_valid therefore rises exactly WIDTH edges after the accepting edge.
REQ-020 DONE SHALL hold sum, cout, out_valid stable until out_ready=1 at a rising edge, then go to IDLE; earliest next accept is the following edge (throughput one operation per WIDTH+2 cycles with out_ready held high).
REQ-021 in_valid in RUN or DONE SHALL be ignored; a, b, cin changes after acceptance SHALL NOT affect the result.
REQ-022 out_ready in IDLE or RUN SHALL have no effect.
REQ-023 Counter width SHALL be ceil(log2(WIDTH+1)) bits; no wrap-around reachable.
REQ-024 All outputs SHALL be driven from registers or decoded directly from the state register; no combinational path from any input to any output.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, clear sum to 0, cout to 0, carry, counter and shift registers to 0, in any state including mid-RUN; an in-flight operation is discarded without out_valid.
REQ-026 After reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification (WIDTH=8)
REQ-028 a=0x0F, b=0x01, cin=0 -> out_valid rises 8 edges after accept; sum=0x10, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 out_ready held 0 for 5 cycles in DONE -> sum, cout, out_valid unchanged, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-031 in_valid=1 with a=0xAA during RUN of 0x12+0x34 -> ignored; result sum=0x46, cout=0.
REQ-032 rst=1 at 4th RUN edge -> IDLE next cycle, sum=0, no out_valid pulse; next operation 0x80+0x80 -> sum=0x00, cout=1.
REQ-033 Exhaustive or random compare of all a, b, cin against a+b+cin with out_ready randomly toggled -> zero mismatches.
